grid_update_arbiter: RTL and testbench

Arbitrates object-grid write requests from the four player interaction paths into a single shadow copy of the kitchen grid, and publishes that shadow to the `object_grid` bus consumed by `graphics` once per frame, at the start of vertical sync. The graphics pipeline therefore always sees a tear-free grid that is stable for a whole frame. Each request is a conditional write (compare-and-swap), so two players grabbing the same item resolve deterministically.

---
 rtl/grid_update_arbiter.sv | 149 ++++++++++++++
 tb/tb_grid_update_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_update_arbiter.sv
// grid_update_arbiter
//
// Collects object-grid writes from the four player interaction paths into one
// shadow copy of the kitchen grid. Once per frame, at the first low cycle of
// vsync, it publishes that shadow to object_grid. Graphics therefore always
// reads a grid that is stable for the whole frame. Every write is a
// compare-and-swap, so two players racing for the same item resolve
// deterministically in round-robin order.
//
// Ports
//   clock        system/pixel clock
//   reset        synchronous, active-low reset
//   vsync        XVGA vertical sync, active low
//   req_valid    per-player request valid
//   req_row      per-player target row
//   req_col      per-player target column (values above COLS-1 are rejected)
//   req_expect   per-player required current value, 4'hF = unconditional
//   req_obj      per-player new cell value
//   req_ready    per-player grant; a transfer is req_valid & req_ready
//   resp_valid   one-cycle response pulse, the cycle after the transfer
//   resp_ok      qualifies resp_valid: 1 when the write was performed
//   object_grid  registered published grid, changes only on commit edges
//   frame_commit one-cycle pulse in the cycle object_grid has just updated

module grid_update_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ROWS    = 8,
    parameter int COLS    = 13,
    parameter int ROW_W   = 3,
    parameter int COL_W   = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               vsync,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0][ROW_W-1:0]      req_row,
    input  logic [NUM_REQ-1:0][COL_W-1:0]      req_col,
    input  logic [NUM_REQ-1:0][3:0]            req_expect,
    input  logic [NUM_REQ-1:0][3:0]            req_obj,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 resp_valid,
    output logic [NUM_REQ-1:0]                 resp_ok,
    output logic [ROWS-1:0][COLS-1:0][3:0]     object_grid,
    output logic                               frame_commit
);

    localparam int               PTR_W     = $clog2(NUM_REQ);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [3:0]       ANY_VALUE = 4'hF;

    logic [ROWS-1:0][COLS-1:0][3:0] shadow;
    logic                           vsync_q;
    logic                           commit_cycle;
    logic [PTR_W-1:0]               rr;
    logic [PTR_W-1:0]               cand;
    logic [PTR_W-1:0]               sel;
    logic                           found;
    logic [NUM_REQ-1:0]             grant;
    logic                           xfer;
    logic [ROW_W-1:0]               sel_row;
    logic [COL_W-1:0]               sel_col;
    logic [3:0]                     sel_expect;
    logic [3:0]                     sel_obj;
    logic [3:0]                     cur_value;
    logic                           col_ok;
    logic                           cas_ok;
    logic                           do_write;

    // First low cycle of vsync. Nothing is granted here, so the shadow is
    // frozen while it is copied out.
    assign commit_cycle = vsync_q & ~vsync;

    // Round-robin search starting at rr. The pointer wraps naturally because
    // NUM_REQ is a power of two.
    always_comb begin
        found = 1'b0;
        sel   = rr;
        cand  = rr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr + PTR_W'(k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        grant = found ? (NUM_REQ'(1) << sel) : '0;
    end

    // Reset and commit cycles both suppress the grant. All other state then
    // holds, so a pending requester simply waits one more cycle.
    assign xfer      = found & ~commit_cycle & reset;
    assign req_ready = xfer ? grant : '0;

    assign sel_row    = req_row[sel];
    assign sel_col    = req_col[sel];
    assign sel_expect = req_expect[sel];
    assign sel_obj    = req_obj[sel];
    assign col_ok     = (sel_col <= LAST_COL);

    // Current shadow value of the targeted cell. An out-of-range column
    // matches no cell and is rejected by col_ok anyway.
    always_comb begin
        cur_value = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (sel_row == ROW_W'(r) && sel_col == COL_W'(c)) begin
                    cur_value = shadow[r][c];
                end
            end
        end
    end

    assign cas_ok   = col_ok && (sel_expect == ANY_VALUE || cur_value == sel_expect);
    assign do_write = xfer & cas_ok;

    // Shadow writes, responses, round-robin pointer and frame publication.
    // A write made at the edge before the commit cycle is already in the
    // shadow when object_grid samples it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shadow       <= '0;
            object_grid  <= '0;
            rr           <= '0;
            vsync_q      <= 1'b1;
            resp_valid   <= '0;
            resp_ok      <= '0;
            frame_commit <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            frame_commit <= commit_cycle;
            resp_valid   <= req_ready;
            resp_ok      <= do_write ? grant : '0;
            if (commit_cycle) begin
                object_grid <= shadow;
            end
            if (xfer) begin
                rr <= sel + 1'b1;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (do_write && sel_row == ROW_W'(r) && sel_col == COL_W'(c)) begin
                        shadow[r][c] <= sel_obj;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_update_arbiter.sv
// Testbench for grid_update_arbiter. The bench runs a directed vector table,
// then a reset/vsync sequence, then randomized traffic. Every cycle it checks
// the DUT against a behavioural model built on integer arrays.

module tb_grid_update_arbiter;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   vsync;
    logic [3:0]             req_valid;
    logic [3:0][2:0]        req_row;
    logic [3:0][3:0]        req_col;
    logic [3:0][3:0]        req_expect;
    logic [3:0][3:0]        req_obj;
    logic [3:0]             req_ready;
    logic [3:0]             resp_valid;
    logic [3:0]             resp_ok;
    logic [7:0][12:0][3:0]  object_grid;
    logic                   frame_commit;

    always #5 clock = ~clock;

    grid_update_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .vsync        (vsync),
        .req_valid    (req_valid),
        .req_row      (req_row),
        .req_col      (req_col),
        .req_expect   (req_expect),
        .req_obj      (req_obj),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ok      (resp_ok),
        .object_grid  (object_grid),
        .frame_commit (frame_commit)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int         m_shadow[8][13];
    int         m_grid[8][13];
    int         m_rr;
    bit         m_vq;
    logic [3:0] exp_rv;
    logic [3:0] exp_ok;
    logic       exp_fc;

    typedef struct {
        logic        rst;
        logic        vs;
        logic [3:0]  valid;
        logic [11:0] row;
        logic [15:0] col;
        logic [15:0] expv;
        logic [15:0] obj;
        logic [3:0]  ready;
        logic [3:0]  rv;
        logic [3:0]  ok;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic rst, logic vs, logic [3:0] valid, logic [11:0] row,
                                logic [15:0] col, logic [15:0] expv, logic [15:0] obj,
                                logic [3:0] ready, logic [3:0] rv, logic [3:0] ok);
        vec_t v;
        v.rst = rst; v.vs = vs; v.valid = valid; v.row = row; v.col = col;
        v.expv = expv; v.obj = obj; v.ready = ready; v.rv = rv; v.ok = ok;
        return v;
    endfunction

    task automatic checkValue(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic checkOutput();
        int bad;
        int br;
        int bc;
        checkValue("resp_valid", int'(resp_valid), int'(exp_rv));
        checkValue("resp_ok", int'(resp_ok), int'(exp_ok));
        checkValue("frame_commit", int'(frame_commit), int'(exp_fc));
        bad = 0; br = 0; bc = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 13; c++) begin
                if (int'(object_grid[r][c]) != m_grid[r][c]) begin
                    if (bad == 0) begin br = r; bc = c; end
                    bad++;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL object_grid[%0d][%0d]: got %0h, expected %0h (%0d cells differ)",
                     br, bc, object_grid[br][bc], m_grid[br][bc], bad);
        end
    endtask

    // Checks req_ready against the model for the current inputs, advances the
    // model by one clock, then checks the registered outputs.
    task automatic applyStimulus();
        int  gi;
        int  r;
        int  c;
        bit  commit;
        #1;
        commit = m_vq && !vsync;
        gi = -1;
        if (reset && !commit) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_rr + k) % 4;
                if (gi < 0 && req_valid[i]) gi = i;
            end
        end
        checkValue("req_ready", int'(req_ready), (gi >= 0) ? (1 << gi) : 0);
        if (!reset) begin
            foreach (m_shadow[a, b]) begin
                m_shadow[a][b] = 0;
                m_grid[a][b]   = 0;
            end
            m_rr = 0; m_vq = 1'b1;
            exp_rv = '0; exp_ok = '0; exp_fc = 1'b0;
        end else begin
            exp_rv = '0; exp_ok = '0; exp_fc = commit;
            if (commit) begin
                foreach (m_shadow[a, b]) m_grid[a][b] = m_shadow[a][b];
            end
            if (gi >= 0) begin
                exp_rv[gi] = 1'b1;
                r = int'(req_row[gi]);
                c = int'(req_col[gi]);
                if (c < 13 && (req_expect[gi] == 4'hF || m_shadow[r][c] == int'(req_expect[gi]))) begin
                    exp_ok[gi] = 1'b1;
                    m_shadow[r][c] = int'(req_obj[gi]);
                end
                m_rr = (gi + 1) % 4;
            end
            m_vq = vsync;
        end
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    initial begin
        int sel;
        int r;
        int c;

        // rst vs valid row     col       expect    obj       ready rv  ok
        tbl[0]  = mk(0, 1, 4'hF, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[1]  = mk(0, 1, 4'hF, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[2]  = mk(0, 1, 4'hF, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[3]  = mk(1, 1, 4'h1, 12'h002, 16'h0005, 16'hFFFF, 16'h0003, 4'h1, 4'h1, 4'h1);
        tbl[4]  = mk(1, 1, 4'h0, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[5]  = mk(1, 0, 4'h0, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[6]  = mk(1, 0, 4'h0, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[7]  = mk(1, 1, 4'h0, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[8]  = mk(1, 1, 4'h6, 12'h000, 16'h0000, 16'hF00F, 16'h0970, 4'h2, 4'h2, 4'h2);
        tbl[9]  = mk(1, 1, 4'h4, 12'h000, 16'h0000, 16'hF00F, 16'h0970, 4'h4, 4'h4, 4'h0);
        tbl[10] = mk(1, 0, 4'h0, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[11] = mk(1, 1, 4'h0, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);
        tbl[12] = mk(1, 1, 4'h8, 12'h200, 16'hD000, 16'hFFFF, 16'h5000, 4'h8, 4'h8, 4'h0);
        for (int i = 0; i < 8; i++) begin
            tbl[13 + i] = mk(1, 1, 4'hF, 12'h6DB, 16'h3210, 16'hFFFF, 16'h4321,
                             4'(1 << (i % 4)), 4'(1 << (i % 4)), 4'(1 << (i % 4)));
        end
        tbl[21] = mk(1, 1, 4'h1, 12'h004, 16'h000C, 16'hFFFF, 16'h000A, 4'h1, 4'h1, 4'h1);
        tbl[22] = mk(1, 0, 4'h8, 12'h6DB, 16'h3210, 16'hFFFF, 16'h4321, 4'h0, 4'h0, 4'h0);
        tbl[23] = mk(1, 0, 4'h8, 12'h6DB, 16'h3210, 16'hFFFF, 16'h4321, 4'h8, 4'h8, 4'h8);
        tbl[24] = mk(1, 1, 4'h0, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 4'h0);

        foreach (m_shadow[a, b]) begin
            m_shadow[a][b] = 0;
            m_grid[a][b]   = 0;
        end
        m_rr = 0; m_vq = 1'b1;
        exp_rv = '0; exp_ok = '0; exp_fc = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 25; i++) begin
            reset      = tbl[i].rst;
            vsync      = tbl[i].vs;
            req_valid  = tbl[i].valid;
            req_row    = tbl[i].row;
            req_col    = tbl[i].col;
            req_expect = tbl[i].expv;
            req_obj    = tbl[i].obj;
            #1;
            checkValue($sformatf("tbl%0d_ready", i), int'(req_ready), int'(tbl[i].ready));
            applyStimulus();
            checkValue($sformatf("tbl%0d_resp_valid", i), int'(resp_valid), int'(tbl[i].rv));
            checkValue($sformatf("tbl%0d_resp_ok", i), int'(resp_ok), int'(tbl[i].ok));
            if (i == 4)  checkValue("grid25_before_commit", int'(object_grid[2][5]), 0);
            if (i == 5) begin
                checkValue("grid25_after_commit", int'(object_grid[2][5]), 3);
                checkValue("commit_pulse", int'(frame_commit), 1);
            end
            if (i == 6)  checkValue("single_commit_vsync_low", int'(frame_commit), 0);
            if (i == 10) checkValue("cas_winner_cell00", int'(object_grid[0][0]), 7);
            if (i == 22) begin
                checkValue("pre_commit_write_4_12", int'(object_grid[4][12]), 10);
                checkValue("rr_write_3_2", int'(object_grid[3][2]), 3);
                checkValue("oor_row1_untouched", int'(object_grid[1][12]), 0);
            end
        end

        $display("[TB] vsync falling edge during reset");
        reset = 1'b0; vsync = 1'b1; req_valid = 4'hF;
        applyStimulus();
        vsync = 1'b0;
        applyStimulus();
        checkValue("no_commit_in_reset_a", int'(frame_commit), 0);
        applyStimulus();
        checkValue("no_commit_in_reset_b", int'(frame_commit), 0);
        vsync = 1'b1;
        applyStimulus();
        reset = 1'b1; req_valid = 4'h0;
        applyStimulus();
        checkValue("grid_cleared_by_reset", int'(object_grid[4][12]), 0);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset     = ($urandom_range(0, 199) != 0);
            vsync     = ((cyc % 25) < 3) ? 1'b0 : 1'b1;
            req_valid = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) begin
                r = int'($urandom_range(0, 7));
                c = int'($urandom_range(0, 15));
                req_row[p] = 3'(r);
                req_col[p] = 4'(c);
                sel = int'($urandom_range(0, 2));
                if (sel == 0)                req_expect[p] = 4'hF;
                else if (sel == 1 && c < 13) req_expect[p] = 4'(m_shadow[r][c]);
                else                         req_expect[p] = 4'($urandom_range(0, 14));
                req_obj[p] = 4'($urandom_range(0, 15));
            end
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
